// File: rtl/accumulator_pkg.sv
// accumulator_pkg: shared types and constants for the streaming accumulator.
//   state_t : FSM encoding (IDLE, ACCUM, DONE)
//   DATA_W  : datapath width in bits
package accumulator_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/adder_16bit.sv
// adder_16bit: 16-bit unsigned ripple-free adder with carry in/out.
//   a, b      : operands
//   carry_in  : carry into bit 0
//   sum       : a + b + carry_in, modulo 2^16
//   overflow  : carry out of bit 15
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);

    logic [16:0] full;

    always_comb begin
        full     = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
        sum      = full[15:0];
        overflow = full[16];
    end

endmodule

// File: rtl/accumulator_16bit.sv
// accumulator_16bit: sums NUM_SAMPLES unsigned 16-bit operands received over a
// valid/ready input, presents the total plus a sticky overflow flag over a
// valid/ready output, then restarts from zero.
//   clk, rst             : clock, asynchronous active-high reset
//   clear                : synchronous abort of the current block
//   in_valid/in_ready    : input handshake, in_data is the operand
//   out_valid/out_ready  : output handshake for out_sum / out_overflow
//   busy                 : FSM is not idle
module accumulator_16bit
    import accumulator_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 4,
    localparam int unsigned CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_overflow,
    output logic              busy
);

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              ovf;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;
    logic              accept;
    logic              last_sample;

    adder_16bit u_adder (
        .a        (acc),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    assign in_ready     = (state != DONE) && !clear;
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state == DONE);
    assign out_sum      = acc;
    assign out_overflow = ovf;
    assign busy         = (state != IDLE);

    // In IDLE count is zero, so this also covers NUM_SAMPLES == 1.
    assign last_sample  = (count == CNT_W'(NUM_SAMPLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= add_sum;
                        ovf   <= ovf | add_ovf;
                        count <= count + CNT_W'(1);
                        state <= last_sample ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag X/Z on operand bits whenever a sample is offered.
    always @(posedge clk) begin
        if (in_valid === 1'b1) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (in_data[i] !== 1'b0 && in_data[i] !== 1'b1) begin
                    $error("accumulator_16bit: in_data[%0d] is %b while in_valid", i, in_data[i]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_accumulator_16bit.sv
module tb_accumulator_16bit;

    localparam int unsigned N = 4;

    typedef struct {
        logic [3:0][15:0] d;
        int               gap;
        logic [15:0]      sum;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_overflow;
    logic        busy;

    int vec_cnt = 0;
    int miscompares = 0;

    exp_t sb[$];
    vec_t vecs[8];

    accumulator_16bit #(
        .NUM_SAMPLES (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Independent reference: 17-bit accumulate, sticky carry.
    function automatic exp_t model(input logic [3:0][15:0] d);
        exp_t        e;
        logic [16:0] t;
        e.sum = 16'h0;
        e.ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t     = {1'b0, e.sum} + {1'b0, d[i]};
            e.sum = t[15:0];
            e.ovf = e.ovf | t[16];
        end
        return e;
    endfunction

    // Present one sample at a negedge; it is taken at the following posedge.
    task automatic send(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_block(input vec_t v);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(v.d[i]);
            if (i < 3) begin
                repeat (v.gap) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
        end
        e.sum = v.sum;
        e.ovf = v.ovf;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic collect(input bit release_out);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_overflow", 32'(out_overflow), 32'(e.ovf));
        if (release_out) begin
            out_ready = 1'b1;
            @(negedge clk);
            check("post_handshake_out_valid", 32'(out_valid), 32'd0);
            check("post_handshake_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        vec_t ones;

        vecs[0] = '{d: {16'd4, 16'd3, 16'd2, 16'd1}, gap: 0, sum: 16'h000A, ovf: 1'b0};
        vecs[1] = '{d: {16'h0000, 16'h0000, 16'h0002, 16'hFFFF}, gap: 0, sum: 16'h0001,
                    ovf: 1'b1};
        vecs[2] = '{d: {16'h0001, 16'h0000, 16'h0000, 16'h0000}, gap: 0, sum: 16'h0001,
                    ovf: 1'b0};
        vecs[3] = '{d: {16'd8, 16'd7, 16'd6, 16'd5}, gap: 2, sum: 16'h001A, ovf: 1'b0};
        vecs[4] = '{d: {16'h1234, 16'h1234, 16'h1234, 16'h1234}, gap: 0, sum: 16'h48D0,
                    ovf: 1'b0};
        for (int i = 5; i < 8; i++) begin
            for (int j = 0; j < 4; j++) vecs[i].d[j] = 16'($urandom_range(0, 65535));
            vecs[i].gap = i - 5;
            e           = model(vecs[i].d);
            vecs[i].sum = e.sum;
            vecs[i].ovf = e.ovf;
        end
        ones = '{d: {16'd1, 16'd1, 16'd1, 16'd1}, gap: 0, sum: 16'h0004, ovf: 1'b0};

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_overflow", 32'(out_overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Basic, wrap/overflow, flag clearing, bubbles
        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i]);
            collect(1'b1);
        end

        // Backpressure in DONE with inputs offered
        out_ready = 1'b0;
        run_block(vecs[0]);
        collect(1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum", 32'(out_sum), 32'h000A);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_busy", 32'(busy), 32'd0);
        run_block(vecs[4]);
        collect(1'b1);

        // Clear mid-block with a sample offered
        send(16'd1);
        send(16'd2);
        @(negedge clk);
        check("clr_acc_before", 32'(out_sum), 32'h0003);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0100;
        #1;
        check("clr_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_out_sum", 32'(out_sum), 32'h0000);
        run_block(ones);
        collect(1'b1);

        // Asynchronous reset mid-block
        send(16'd1);
        send(16'd2);
        @(negedge clk);
        in_valid = 1'b0;
        check("rstmid_acc_before", 32'(out_sum), 32'h0003);
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_out_sum", 32'(out_sum), 32'd0);
        check("rstmid_out_overflow", 32'(out_overflow), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        #1;
        rst = 1'b0;
        run_block(ones);
        collect(1'b1);

        // Random blocks against the reference model, varied gaps
        for (int i = 5; i < 8; i++) begin
            run_block(vecs[i]);
            collect(1'b1);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
